// File: rtl/axi_ram_responder.sv
// AXI4 slave block-RAM responder.
// Accepts FIXED/INCR (WRAP treated as INCR) bursts on independent read and write
// channels, stores full-width beats in on-chip RAM and answers with B/R carrying the
// request ID. Stands in for the SDRAM controller behind the same AXI port widths.
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_axi_aw* / o_axi_awready write address channel (size ignored, full-width beats)
//   i_axi_w*  / o_axi_wready  write data channel, byte strobes honoured
//   o_axi_b*  / i_axi_bready  write response, SLVERR on misplaced wlast
//   i_axi_ar* / o_axi_arready read address channel
//   o_axi_r*  / i_axi_rready  read data channel, one registered RAM read of latency
module axi_ram_responder #(
  parameter int unsigned C_AXI_ID_WIDTH   = 6,
  parameter int unsigned C_AXI_DATA_WIDTH = 128,
  parameter int unsigned C_AXI_ADDR_WIDTH = 28,
  parameter int unsigned LGMEMSZ          = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic [7:0]                    i_axi_awlen,
  input  logic [2:0]                    i_axi_awsize,
  input  logic [1:0]                    i_axi_awburst,
  input  logic                          i_axi_awvalid,
  output logic                          o_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
  input  logic                          i_axi_wlast,
  input  logic                          i_axi_wvalid,
  output logic                          o_axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     o_axi_bid,
  output logic [1:0]                    o_axi_bresp,
  output logic                          o_axi_bvalid,
  input  logic                          i_axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
  input  logic [7:0]                    i_axi_arlen,
  input  logic [2:0]                    i_axi_arsize,
  input  logic [1:0]                    i_axi_arburst,
  input  logic                          i_axi_arvalid,
  output logic                          o_axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     o_axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
  output logic [1:0]                    o_axi_rresp,
  output logic                          o_axi_rlast,
  output logic                          o_axi_rvalid,
  input  logic                          i_axi_rready
);

  localparam int unsigned StrbW = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = LGMEMSZ - OffW;
  localparam int unsigned Depth = 1 << IdxW;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RBurst} r_state_e;

  // Goes high on the first clock after reset release; holds both ready outputs low
  // until then so the release is synchronous to i_clk.
  logic run_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) run_q <= 1'b0;
    else            run_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write side
  w_state_e                  w_state_q, w_state_d;
  logic [C_AXI_ID_WIDTH-1:0] bid_q;
  logic [IdxW-1:0]           widx_q;
  logic [7:0]                wlen_q, wcnt_q;
  logic                      wfixed_q, werr_q;
  logic                      aw_hs, w_hs, w_final;

  assign aw_hs   = i_axi_awvalid && o_axi_awready;
  assign w_hs    = i_axi_wvalid && o_axi_wready;
  assign w_final = (wcnt_q == wlen_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) w_state_q <= WIdle;
    else            w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && w_final) w_state_d = WResp;
      WResp:   if (i_axi_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    o_axi_awready = (w_state_q == WIdle) && run_q;
    o_axi_wready  = (w_state_q == WData);
    o_axi_bvalid  = (w_state_q == WResp);
    o_axi_bresp   = ((w_state_q == WResp) && werr_q) ? 2'b10 : 2'b00;
  end

  assign o_axi_bid = bid_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bid_q    <= '0;
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wfixed_q <= 1'b0;
      werr_q   <= 1'b0;
    end else if (aw_hs) begin
      bid_q    <= i_axi_awid;
      widx_q   <= i_axi_awaddr[LGMEMSZ-1:OffW];
      wlen_q   <= i_axi_awlen;
      wcnt_q   <= '0;
      wfixed_q <= (i_axi_awburst == 2'b00);
      werr_q   <= 1'b0;
    end else if (w_hs) begin
      wcnt_q <= wcnt_q + 8'd1;
      if (!wfixed_q) widx_q <= widx_q + 1'b1;
      // wlast must coincide exactly with the final beat
      if (i_axi_wlast != w_final) werr_q <= 1'b1;
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_e                  r_state_q, r_state_d;
  logic [C_AXI_ID_WIDTH-1:0] rid_q;
  logic [IdxW-1:0]           ridx_q;
  logic [7:0]                rlen_q;
  logic [8:0]                rcnt_q;   // beats issued to the RAM so far
  logic                      rfixed_q, rvalid_q, rlast_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      ar_hs, r_hs, r_issue;

  assign ar_hs = i_axi_arvalid && o_axi_arready;
  assign r_hs  = rvalid_q && i_axi_rready;
  // The RAM output register doubles as the R stage: a new read is only issued when
  // that stage is empty or being consumed, so stalled data stays put without bubbles.
  assign r_issue = (r_state_q == RBurst) && (rcnt_q <= {1'b0, rlen_q}) &&
                   (!rvalid_q || i_axi_rready);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state_q <= RIdle;
    else            r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RBurst;
      RBurst:  if (r_hs && rlast_q) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    o_axi_arready = (r_state_q == RIdle) && run_q;
    o_axi_rvalid  = rvalid_q;
    o_axi_rlast   = rlast_q;
    o_axi_rresp   = 2'b00;
    o_axi_rid     = rid_q;
    o_axi_rdata   = rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rid_q    <= '0;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rfixed_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        rid_q    <= i_axi_arid;
        ridx_q   <= i_axi_araddr[LGMEMSZ-1:OffW];
        rlen_q   <= i_axi_arlen;
        rcnt_q   <= '0;
        rfixed_q <= (i_axi_arburst == 2'b00);
      end
      if (r_issue) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (rcnt_q[7:0] == rlen_q);
        rcnt_q   <= rcnt_q + 9'd1;
        if (!rfixed_q) ridx_q <= ridx_q + 1'b1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------------- RAM
  // Read and write on the same edge: the read sees the pre-write word.
  logic [C_AXI_DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge i_clk) begin
    if (w_hs) begin
      for (int b = 0; b < StrbW; b++) begin
        if (i_axi_wstrb[b]) mem[widx_q][b*8 +: 8] <= i_axi_wdata[b*8 +: 8];
      end
    end
    if (r_issue) rdata_q <= mem[ridx_q];
  end

  logic unused_ok;
  assign unused_ok = ^{i_axi_awsize, i_axi_arsize, i_axi_awaddr, i_axi_araddr};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed self-checking bench for axi_ram_responder. Inputs are driven and outputs
// sampled on the falling edge; a shadow word array tracks what the bench wrote.
module tb_axi_ram_responder;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic [5:0]   i_axi_awid, i_axi_arid;
  logic [27:0]  i_axi_awaddr, i_axi_araddr;
  logic [7:0]   i_axi_awlen, i_axi_arlen;
  logic [2:0]   i_axi_awsize, i_axi_arsize;
  logic [1:0]   i_axi_awburst, i_axi_arburst;
  logic         i_axi_awvalid, i_axi_arvalid;
  logic         o_axi_awready, o_axi_arready;
  logic [127:0] i_axi_wdata;
  logic [15:0]  i_axi_wstrb;
  logic         i_axi_wlast, i_axi_wvalid, o_axi_wready;
  logic [5:0]   o_axi_bid, o_axi_rid;
  logic [1:0]   o_axi_bresp, o_axi_rresp;
  logic         o_axi_bvalid, i_axi_bready;
  logic [127:0] o_axi_rdata;
  logic         o_axi_rlast, o_axi_rvalid, i_axi_rready;

  int n_checks = 0;
  int n_bad    = 0;
  logic [127:0] model [4096];
  logic [127:0] last_rdata;

  axi_ram_responder dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_axi_awid    (i_axi_awid),
    .i_axi_awaddr  (i_axi_awaddr),
    .i_axi_awlen   (i_axi_awlen),
    .i_axi_awsize  (i_axi_awsize),
    .i_axi_awburst (i_axi_awburst),
    .i_axi_awvalid (i_axi_awvalid),
    .o_axi_awready (o_axi_awready),
    .i_axi_wdata   (i_axi_wdata),
    .i_axi_wstrb   (i_axi_wstrb),
    .i_axi_wlast   (i_axi_wlast),
    .i_axi_wvalid  (i_axi_wvalid),
    .o_axi_wready  (o_axi_wready),
    .o_axi_bid     (o_axi_bid),
    .o_axi_bresp   (o_axi_bresp),
    .o_axi_bvalid  (o_axi_bvalid),
    .i_axi_bready  (i_axi_bready),
    .i_axi_arid    (i_axi_arid),
    .i_axi_araddr  (i_axi_araddr),
    .i_axi_arlen   (i_axi_arlen),
    .i_axi_arsize  (i_axi_arsize),
    .i_axi_arburst (i_axi_arburst),
    .i_axi_arvalid (i_axi_arvalid),
    .o_axi_arready (o_axi_arready),
    .o_axi_rid     (o_axi_rid),
    .o_axi_rdata   (o_axi_rdata),
    .o_axi_rresp   (o_axi_rresp),
    .o_axi_rlast   (o_axi_rlast),
    .o_axi_rvalid  (o_axi_rvalid),
    .i_axi_rready  (i_axi_rready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [27:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    i_axi_awid = id; i_axi_awaddr = addr; i_axi_awlen = len; i_axi_awburst = burst;
    i_axi_awvalid = 1'b1;
    while (!o_axi_awready && n < 50) begin @(negedge i_clk); n++; end
    if (n >= 50) check("aw_timeout", 0, 1);
    @(negedge i_clk);
    i_axi_awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [27:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    i_axi_arid = id; i_axi_araddr = addr; i_axi_arlen = len; i_axi_arburst = burst;
    i_axi_arvalid = 1'b1;
    while (!o_axi_arready && n < 50) begin @(negedge i_clk); n++; end
    if (n >= 50) check("ar_timeout", 0, 1);
    @(negedge i_clk);
    i_axi_arvalid = 1'b0;
  endtask

  // Beat k carries base+k; wlast is raised on beat last_at (len for a legal burst).
  task automatic write_burst(input logic [5:0] id, input logic [27:0] addr, input int len,
                             input logic [1:0] burst, input logic [127:0] base,
                             input logic [15:0] strb, input int last_at);
    logic [11:0]  idx;
    logic [127:0] d, mask;
    int n;
    aw_send(id, addr, len[7:0], burst);
    check("w_ready", o_axi_wready, 1);
    idx = addr[15:4];
    for (int k = 0; k <= len; k++) begin
      d = base + 128'(k);
      i_axi_wdata = d; i_axi_wstrb = strb; i_axi_wlast = (k == last_at); i_axi_wvalid = 1'b1;
      n = 0;
      while (!o_axi_wready && n < 50) begin @(negedge i_clk); n++; end
      if (n >= 50) check("w_timeout", 0, 1);
      @(negedge i_clk);
      for (int b = 0; b < 16; b++) mask[b*8 +: 8] = {8{strb[b]}};
      model[idx] = (model[idx] & ~mask) | (d & mask);
      if (burst != 2'b00) idx = idx + 12'd1;
    end
    i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0;
    check("b_latency", o_axi_bvalid, 1);
    i_axi_bready = 1'b1;
    n = 0;
    while (!o_axi_bvalid && n < 50) begin @(negedge i_clk); n++; end
    check("bid", o_axi_bid, id);
    check("bresp", o_axi_bresp, (last_at == len) ? 2'b00 : 2'b10);
    @(negedge i_clk);
    i_axi_bready = 1'b0;
  endtask

  // toggle=1 drives rready 1,0,1,0,... and checks that stalled data holds.
  task automatic read_burst(input logic [5:0] id, input logic [27:0] addr, input int len,
                            input logic [1:0] burst, input bit toggle);
    logic [11:0]  idx;
    logic [127:0] held;
    bit stalled = 1'b0;
    int beat = 0;
    int cyc = 0;
    ar_send(id, addr, len[7:0], burst);
    check("r_lat_n1", o_axi_rvalid, 0);
    @(negedge i_clk);
    check("r_lat_n2", o_axi_rvalid, 1);
    idx = addr[15:4];
    while (beat <= len && cyc < 200) begin
      i_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (o_axi_rvalid) begin
        if (stalled) check("r_hold", o_axi_rdata, held);
        if (i_axi_rready) begin
          check("rdata", o_axi_rdata, model[idx]);
          check("rlast", o_axi_rlast, beat == len);
          check("rid", o_axi_rid, id);
          check("rresp", o_axi_rresp, 0);
          last_rdata = o_axi_rdata;
          beat++;
          if (burst != 2'b00) idx = idx + 12'd1;
          stalled = 1'b0;
        end else begin
          held = o_axi_rdata;
          stalled = 1'b1;
        end
      end
      @(negedge i_clk);
      cyc++;
    end
    i_axi_rready = 1'b0;
    if (beat <= len) check("r_timeout", beat, len + 1);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_axi_awid = '0; i_axi_awaddr = '0; i_axi_awlen = '0; i_axi_awsize = 3'd4;
    i_axi_awburst = 2'b01; i_axi_awvalid = 1'b0;
    i_axi_arid = '0; i_axi_araddr = '0; i_axi_arlen = '0; i_axi_arsize = 3'd4;
    i_axi_arburst = 2'b01; i_axi_arvalid = 1'b0;
    i_axi_wdata = '0; i_axi_wstrb = '0; i_axi_wlast = 1'b0; i_axi_wvalid = 1'b0;
    i_axi_bready = 1'b0; i_axi_rready = 1'b0;
    for (int i = 0; i < 4096; i++) model[i] = '0;

    repeat (3) @(negedge i_clk);
    check("rst_awready", o_axi_awready, 0);
    check("rst_wready", o_axi_wready, 0);
    check("rst_bvalid", o_axi_bvalid, 0);
    check("rst_arready", o_axi_arready, 0);
    check("rst_rvalid", o_axi_rvalid, 0);
    check("rst_rlast", o_axi_rlast, 0);
    check("rst_bresp", o_axi_bresp, 0);
    check("rst_rresp", o_axi_rresp, 0);
    check("rst_bid", o_axi_bid, 0);
    check("rst_rid", o_axi_rid, 0);
    i_reset_n = 1'b1;
    #1 check("rel_awready", o_axi_awready, 0);
    @(negedge i_clk);
    check("rel1_awready", o_axi_awready, 1);
    check("rel1_arready", o_axi_arready, 1);

    // Single beat write then read
    write_burst(6'd5, 28'h40, 0, 2'b01, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 0);
    read_burst(6'd9, 28'h40, 0, 2'b01, 1'b0);
    check("single_data", last_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);

    // INCR burst of 8, read back with rready toggling
    write_burst(6'd1, 28'h100, 7, 2'b01, 128'h0, 16'hFFFF, 7);
    read_burst(6'd2, 28'h100, 7, 2'b01, 1'b1);
    check("incr_last", last_rdata, 128'd7);

    // Partial strobe over an all-ones word
    write_burst(6'd3, 28'h200, 0, 2'b01, {128{1'b1}}, 16'hFFFF, 0);
    write_burst(6'd3, 28'h200, 0, 2'b01, 128'h0, 16'h000F, 0);
    read_burst(6'd4, 28'h200, 0, 2'b01, 1'b0);
    check("strb_data", last_rdata, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

    // FIXED burst: all four beats hit one word, last one wins
    write_burst(6'd6, 28'h300, 3, 2'b00, 128'd1, 16'hFFFF, 3);
    read_burst(6'd7, 28'h300, 0, 2'b01, 1'b0);
    check("fixed_data", last_rdata, 128'd4);

    // INCR from the top word wraps to word 0
    write_burst(6'd8, 28'hFFF0, 1, 2'b01, 128'hA0, 16'hFFFF, 1);
    read_burst(6'd10, 28'h0, 0, 2'b01, 1'b0);
    check("wrap_word0", last_rdata, 128'hA1);
    // Upper address bits alias onto the same word
    read_burst(6'd11, 28'h10040, 0, 2'b01, 1'b0);
    check("alias_data", last_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Early wlast: all beats still land, response is SLVERR
    write_burst(6'd12, 28'h400, 3, 2'b01, 128'h10, 16'hFFFF, 1);
    read_burst(6'd13, 28'h400, 3, 2'b01, 1'b0);
    check("err_last_beat", last_rdata, 128'h13);

    // Simultaneous AW and AR to one word: read returns the old contents
    i_axi_awid = 6'd14; i_axi_awaddr = 28'h40; i_axi_awlen = 8'd0; i_axi_awburst = 2'b01;
    i_axi_arid = 6'd15; i_axi_araddr = 28'h40; i_axi_arlen = 8'd0; i_axi_arburst = 2'b01;
    i_axi_awvalid = 1'b1; i_axi_arvalid = 1'b1;
    check("cc_awready", o_axi_awready, 1);
    check("cc_arready", o_axi_arready, 1);
    @(negedge i_clk);
    i_axi_awvalid = 1'b0; i_axi_arvalid = 1'b0;
    check("cc_wready", o_axi_wready, 1);
    i_axi_wdata = 128'hDEAD_BEEF; i_axi_wstrb = 16'hFFFF; i_axi_wlast = 1'b1;
    i_axi_wvalid = 1'b1; i_axi_rready = 1'b1; i_axi_bready = 1'b1;
    @(negedge i_clk);
    i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0;
    check("cc_rvalid", o_axi_rvalid, 1);
    check("cc_old_data", o_axi_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    check("cc_bvalid", o_axi_bvalid, 1);
    @(negedge i_clk);
    i_axi_rready = 1'b0; i_axi_bready = 1'b0;
    model[12'h004] = 128'hDEAD_BEEF;
    read_burst(6'd16, 28'h40, 0, 2'b01, 1'b0);
    check("cc_new_data", last_rdata, 128'hDEAD_BEEF);

    // Reset in the middle of a read burst
    ar_send(6'd17, 28'h100, 8'd7, 2'b01);
    i_axi_rready = 1'b1;
    repeat (2) @(negedge i_clk);
    check("mid_rvalid", o_axi_rvalid, 1);
    i_axi_rready = 1'b0;
    i_reset_n = 1'b0;
    #1;
    check("mrst_rvalid", o_axi_rvalid, 0);
    check("mrst_rlast", o_axi_rlast, 0);
    check("mrst_arready", o_axi_arready, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1 check("mrel_arready0", o_axi_arready, 0);
    @(negedge i_clk);
    check("mrel_arready1", o_axi_arready, 1);
    check("mrel_rvalid", o_axi_rvalid, 0);
    // RAM contents survive reset
    read_burst(6'd18, 28'h100, 7, 2'b01, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
